vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Parametrised raster timing generator. Successor to the fixed 640x480 sync block.
- Produces h/v sync, video_on, pixel coordinates, a pixel tick and frame/line markers for any mode. Porch widths, sync widths, sync polarity and the pixel clock divider are all parameters.
- Adds a run enable, a frame counter, and registered outputs that are mutually aligned.
- Sits between the system clock and the pixel/character renderers feeding the VGA DAC pins.

Parameters:
- H_DISPLAY, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels after active area)
- H_SYNC, 96, horizontal sync pulse width
- H_BACK, 48, horizontal back porch
- V_DISPLAY, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, active level of hsync (0 = active-low)
- V_SYNC_POL, 0, active level of vsync
- CLK_DIV, 2, system clocks per pixel (>=1)
- CNT_W, 10, width of pixel_x/pixel_y; must hold H_TOTAL-1 and V_TOTAL-1
- FCNT_W, 16, width of frame_cnt

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  run enable; low freezes all state
- hsync  out  1  horizontal sync, polarity per H_SYNC_POL
- vsync  out  1  vertical sync, polarity per V_SYNC_POL
- video_on  out  1  high while position is inside the active area
- p_tick  out  1  high on the last clk of each pixel period
- pixel_x  out  CNT_W  current horizontal position 0..H_TOTAL-1
- pixel_y  out  CNT_W  current vertical position 0..V_TOTAL-1
- line_start  out  1  one-clk pulse on entry to pixel_x=0
- frame_start  out  1  one-clk pulse on entry to (0,0)
- frame_cnt  out  FCNT_W  count of frames started, wraps modulo 2^FCNT_W

Behaviour:
- Derived totals: H_TOTAL = sum of the four H_* widths; V_TOTAL = sum of the four V_* widths. Line order is display, front porch, sync, back porch.
- Divider: div counts 0..CLK_DIV-1 while en=1, then wraps to 0.
  - p_tick = en & (div==CLK_DIV-1), combinational.
  - With CLK_DIV=1, p_tick = en.
  - p_tick is forced 0 while reset_n is low.
- Advance: on a clk edge with p_tick=1:
  - pixel_x increments; at H_TOTAL-1 it wraps to 0.
  - On the x wrap, pixel_y increments; at V_TOTAL-1 it wraps to 0.
- Registered outputs: hsync, vsync, video_on, line_start, frame_start and frame_cnt are computed from the next-state counter values and registered on the same edge as pixel_x/pixel_y. Coordinates and these outputs are therefore always consistent with zero relative skew.
- Decode rules:
  - hsync active when H_DISPLAY+H_FRONT <= x <= H_DISPLAY+H_FRONT+H_SYNC-1.
  - vsync active when V_DISPLAY+V_FRONT <= y <= V_DISPLAY+V_FRONT+V_SYNC-1.
  - video_on = (x < H_DISPLAY) & (y < V_DISPLAY).
- Marker pulses:
  - line_start is high for exactly one clk: the edge at which x becomes 0. It is cleared on the next clk even if CLK_DIV > 1.
  - frame_start behaves the same way at (0,0).
  - frame_cnt increments on that same edge.
- Reset (async assert, any time including mid-frame):
  - pixel_x = H_TOTAL-1, pixel_y = V_TOTAL-1, div = 0.
  - hsync/vsync at their inactive level (~POL).
  - video_on, line_start, frame_start and frame_cnt all 0.
  - Because of these reset values, the first p_tick after reset enters (0,0) and emits frame_start, after which frame_cnt = 1.
- en=0: div, counters and all registered outputs hold their values. line_start/frame_start are cleared to 0 and not re-fired while en stays low. Resuming continues from the held position with no skipped or repeated pixel.
- Boundaries:
  - The x and y wraps in the same tick are simultaneous; the resulting frame_start and line_start pulses coincide.
  - frame_cnt wraps from all-ones to 0 with no flag.
- No combinational path from inputs to outputs, except en feeding p_tick.

Test Plan:
- Defaults, en=1, release reset:
  - p_tick on every 2nd clk.
  - First tick gives (0,0) with frame_start=line_start=1 and frame_cnt=1.
  - hsync low exactly for x=656..751; vsync low for y=490..491.
  - Next frame_start arrives 840000 clks later.
- Small mode, H=4/1/2/1, V=3/1/1/1, CLK_DIV=1, both POL=1:
  - x sequence 0..7 repeating; hsync high only at x=5,6; video_on only for x<4, y<3.
  - 48-clk frame period.
- Enable freeze, defaults: drop en for 37 clks at (100,20).
  - Outputs hold; p_tick=0; no pulses.
  - On resume, the next tick gives (101,20).
- Reset mid-frame at (300,250) during div=1:
  - Outputs go immediately to reset values; frame_cnt=0.
  - After release, frame_start fires on the first p_tick.
- FCNT_W=2, small mode: after 5 frame_starts, frame_cnt reads 1 (wrapped from 3 through 0).
- CLK_DIV=3: p_tick duty is 1 of 3; line_start is high for 1 clk only, not 3.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel-clock divider, x/y position
// counters and sync/blank/marker decode. Every output except p_tick is a
// register loaded from the next-state position, so all of them change together.
module vga_timing_gen #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int CLK_DIV    = 2,
  parameter int CNT_W      = 10,
  parameter int FCNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  output logic              hsync,
  output logic              vsync,
  output logic              video_on,
  output logic              p_tick,
  output logic [CNT_W-1:0]  pixel_x,
  output logic [CNT_W-1:0]  pixel_y,
  output logic              line_start,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] X_ACT    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] Y_ACT    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic             HS_ACT   = 1'(H_SYNC_POL);
  localparam logic             VS_ACT   = 1'(V_SYNC_POL);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  x_q, x_d, y_q, y_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d;
  logic              video_on_q, video_on_d;
  logic              line_start_q, line_start_d;
  logic              frame_start_q, frame_start_d;
  logic              tick;

  // The pixel tick is the last system clock of each pixel period; reset masks it.
  assign tick   = en & (div_q == DIV_LAST);
  assign p_tick = reset_n & tick;

  // Next-state position plus the decode of that position, so the registered
  // flags line up with the registered coordinates on the same edge.
  always_comb begin
    div_d = div_q;
    x_d   = x_q;
    y_d   = y_q;
    if (en) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end
    if (tick) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + CNT_W'(1);
      end else begin
        x_d = x_q + CNT_W'(1);
      end
    end
    hsync_d       = ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) ? HS_ACT : ~HS_ACT;
    vsync_d       = ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) ? VS_ACT : ~VS_ACT;
    video_on_d    = (x_d < X_ACT) && (y_d < Y_ACT);
    line_start_d  = tick && (x_d == '0);
    frame_start_d = line_start_d && (y_d == '0);
    frame_cnt_d   = frame_start_d ? frame_cnt_q + FCNT_W'(1) : frame_cnt_q;
  end

  // State and output registers; reset parks the raster on the last pixel so the
  // first tick afterwards lands on (0,0) and announces a new frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q         <= '0;
      x_q           <= X_LAST;
      y_q           <= Y_LAST;
      hsync_q       <= ~HS_ACT;
      vsync_q       <= ~VS_ACT;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      div_q         <= div_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
